piso_tx: RTL and testbench

//   Parallel-in serial-out transmitter; the transmit end of the team's sipo serial link.

---
 rtl/piso_tx_pkg.sv | 32 +++
 rtl/piso_tx_gap_timer.sv | 40 ++++
 rtl/piso_tx.sv | 162 ++++++++++++++++
 tb/tb_piso_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// ---------------------------------------------------------------------------
// piso_tx_pkg
//   Shared definitions for the parallel-in serial-out transmitter:
//   FSM state encodings, the gap-timer width and a helper that turns the
//   gap length parameter into a timer load value.
// ---------------------------------------------------------------------------
package piso_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } piso_state_e;

  // The inter-word gap is at most 15 cycles, so a 4-bit timer covers it.
  localparam int GAP_CNT_W = 4;
  localparam int GAP_MAX   = 15;

  // Clamp a gap length into the range the timer can represent.
  function automatic logic [GAP_CNT_W-1:0] gap_load(input int n);
    logic [GAP_CNT_W-1:0] v;
    if (n > GAP_MAX) begin
      v = GAP_CNT_W'(GAP_MAX);
    end else if (n < 0) begin
      v = '0;
    end else begin
      v = GAP_CNT_W'(n);
    end
    return v;
  endfunction

endpackage

// File: rtl/piso_tx_gap_timer.sv
// ---------------------------------------------------------------------------
// piso_tx_gap_timer
//   4-bit down-counter that times the idle gap between serial words.
//   Loaded with CYCLES when i_start is high; o_done is high during the last
//   gap cycle so the FSM can leave GAP on the following edge.
// Ports
//   i_clk    in   1   clock, rising edge
//   i_rst    in   1   synchronous active-low reset
//   i_start  in   1   load the counter (FSM is entering GAP at this edge)
//   o_done   out  1   current cycle is the final gap cycle
// ---------------------------------------------------------------------------
module piso_tx_gap_timer
  import piso_tx_pkg::*;
#(
  parameter int CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  output logic o_done
);

  localparam logic [GAP_CNT_W-1:0] ONE = GAP_CNT_W'(1);

  logic [GAP_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= gap_load(CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  // A count of one means this is the last of the CYCLES gap cycles.
  assign o_done = (r_cnt == ONE);

endmodule

// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx
//   Parallel-in serial-out transmitter, the transmit end of the sipo serial
//   link. A WIDTH-bit word is accepted through a load/ready handshake and
//   shifted out one bit per clock, qualified by dout_valid, with last marking
//   the final bit of each word. Optional forced idle gap between words.
// Parameters
//   WIDTH       bits per word (>= 2)
//   MSB_FIRST   1: din[WIDTH-1] sent first, 0: din[0] sent first
//   GAP_CYCLES  idle cycles forced between words (0..15)
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous active-low reset
//   din         in   WIDTH  parallel word, captured when a load is accepted
//   load        in   1      producer request to transfer din
//   ready       out  1      a load is accepted this cycle if load is high
//   dout        out  1      serial data bit (0 when not valid)
//   dout_valid  out  1      dout carries a payload bit
//   last        out  1      dout is the final bit of the word
// ---------------------------------------------------------------------------
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               NO_GAP   = (GAP_CYCLES == 0);
  localparam bit               SEND_MSB = (MSB_FIRST != 0);

  piso_state_e      r_state;
  piso_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_dout;
  logic             r_vld;
  logic             r_last;
  logic             w_final;
  logic             w_ready;
  logic             w_accept;
  logic             w_gap_done;
  logic             w_send_bit;
  logic             w_shift_vld;

  // Move the next bit to the send position; vacated bits fill with 0.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] s;
    if (SEND_MSB) begin
      s = {w[WIDTH-2:0], 1'b0};
    end else begin
      s = {1'b0, w[WIDTH-1:1]};
    end
    return s;
  endfunction

  // The shift register always holds the bit currently on dout at its send
  // position, and r_cnt is that bit's index within the word.
  assign w_final  = (r_state == ST_SHIFT) && (r_cnt == LAST_IDX);

  // Back-to-back loads are only possible on the final bit when no gap is
  // forced; reset low blocks every load.
  assign w_ready  = rst && ((r_state == ST_IDLE) || (w_final && NO_GAP));
  assign w_accept = load && w_ready;
  assign ready    = w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SHIFT;
          w_shift_nxt = din;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHIFT: begin
        if (!w_final) begin
          w_shift_nxt = shift_once(r_shift);
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end else if (w_accept) begin
          w_shift_nxt = din;
          w_cnt_nxt   = '0;
        end else begin
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = NO_GAP ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_gap_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_shift_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so that the first bit
  // appears in the cycle right after the accepting edge, yet stay registered.
  assign w_shift_vld = (w_state_nxt == ST_SHIFT);
  assign w_send_bit  = SEND_MSB ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_shift_vld && w_send_bit;
      r_vld   <= w_shift_vld;
      r_last  <= w_shift_vld && (w_cnt_nxt == LAST_IDX);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_vld;
  assign last       = r_last;

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      piso_tx_gap_timer #(
        .CYCLES (GAP_CYCLES)
      ) u_gap_timer (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start ((r_state == ST_SHIFT) && (w_state_nxt == ST_GAP)),
        .o_done  (w_gap_done)
      );
    end else begin : g_no_gap
      // GAP is unreachable without a gap; leave it at once if ever entered.
      assign w_gap_done = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_piso_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_tx
//   Three transmitters with different configurations share one clock:
//     0: MSB first, no gap    1: LSB first, no gap    2: MSB first, 2-cycle gap
//   Expected {dout_valid, dout, last} beats are queued per instance when a
//   load is known to be accepted and popped one per cycle; an empty queue
//   means the instance must be silent that cycle.
// ---------------------------------------------------------------------------
module tb_piso_tx;

  logic       clk;
  logic       rst;
  logic       ld   [3];
  logic [3:0] di   [3];
  logic       rdy  [3];
  logic       dout [3];
  logic       vld  [3];
  logic       last [3];

  logic [2:0] sb [3][$];

  int n_pass;
  int n_total;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(0)) u_msb (
    .clk(clk), .rst(rst), .din(di[0]), .load(ld[0]), .ready(rdy[0]),
    .dout(dout[0]), .dout_valid(vld[0]), .last(last[0])
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(0), .GAP_CYCLES(0)) u_lsb (
    .clk(clk), .rst(rst), .din(di[1]), .load(ld[1]), .ready(rdy[1]),
    .dout(dout[1]), .dout_valid(vld[1]), .last(last[1])
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP_CYCLES(2)) u_gap (
    .clk(clk), .rst(rst), .din(di[2]), .load(ld[2]), .ready(rdy[2]),
    .dout(dout[2]), .dout_valid(vld[2]), .last(last[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int d, input logic [3:0] w, input bit msb);
    logic b;
    for (int i = 0; i < 4; i++) begin
      b = msb ? w[3-i] : w[i];
      sb[d].push_back({1'b1, b, (i == 3)});
    end
  endtask

  task automatic monitor();
    logic [2:0] exp;
    for (int d = 0; d < 3; d++) begin
      exp = (sb[d].size() != 0) ? sb[d].pop_front() : 3'b000;
      check($sformatf("out%0d{vld,dout,last}", d),
            {29'd0, vld[d], dout[d], last[d]}, {29'd0, exp});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic check_ready(input int d, input logic exp);
    #1;
    check($sformatf("ready%0d", d), {31'd0, rdy[d]}, {31'd0, exp});
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    // Reset held low with load high: load dropped, all outputs quiet.
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      ld[d] = 1'b1;
      di[d] = 4'hF;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) check_ready(d, 1'b0);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) ld[d] = 1'b0;
    for (int d = 0; d < 3; d++) check_ready(d, 1'b1);
    tick();
    tick();

    // MSB first, 1001 from IDLE.
    di[0] = 4'b1001;
    ld[0] = 1'b1;
    push_word(0, 4'b1001, 1'b1);
    tick();
    ld[0] = 1'b0;
    check_ready(0, 1'b0);
    repeat (3) tick();
    tick();
    check_ready(0, 1'b1);

    // LSB first, 1101 -> 1,0,1,1 then IDLE.
    di[1] = 4'b1101;
    ld[1] = 1'b1;
    push_word(1, 4'b1101, 1'b0);
    tick();
    ld[1] = 1'b0;
    repeat (3) tick();
    tick();
    check_ready(1, 1'b1);

    // No gap: load held with A then 5, 8 contiguous bits.
    di[0] = 4'hA;
    ld[0] = 1'b1;
    push_word(0, 4'hA, 1'b1);
    tick();
    di[0] = 4'h5;
    push_word(0, 4'h5, 1'b1);
    check_ready(0, 1'b0);
    repeat (3) tick();
    check_ready(0, 1'b1);
    tick();
    ld[0] = 1'b0;
    repeat (3) tick();
    tick();

    // Two-cycle gap: same stimulus, second word waits for IDLE.
    di[2] = 4'hA;
    ld[2] = 1'b1;
    push_word(2, 4'hA, 1'b1);
    tick();
    di[2] = 4'h5;
    repeat (3) tick();
    check_ready(2, 1'b0);
    tick();
    check_ready(2, 1'b0);
    tick();
    check_ready(2, 1'b0);
    tick();
    check_ready(2, 1'b1);
    push_word(2, 4'h5, 1'b1);
    tick();
    ld[2] = 1'b0;
    repeat (3) tick();
    tick();

    // Mid-word load ignored, then reset after bit 2 abandons the word.
    di[0] = 4'b1001;
    ld[0] = 1'b1;
    push_word(0, 4'b1001, 1'b1);
    tick();
    di[0] = 4'h3;
    check_ready(0, 1'b0);
    tick();
    ld[0] = 1'b0;
    rst   = 1'b0;
    check_ready(0, 1'b0);
    sb[0].delete();
    tick();
    rst = 1'b1;
    check_ready(0, 1'b1);
    tick();
    tick();

    for (int d = 0; d < 3; d++) begin
      check($sformatf("sb%0d_drained", d), sb[d].size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
